w_stream_gen: RTL and testbench

Serial stimulus source that sits directly upstream of the FSM block and drives its one-bit `w` input. It captures a parallel pattern on a start request and shifts it out LSB-first, holding each bit for a programmable number of clocks. It reports busy and completion so a controller or bench can sequence patterns into the FSM deterministically.

---
 rtl/w_stream_gen_pkg.sv | 24 ++
 rtl/w_stream_gen_if.sv | 36 +++
 rtl/w_stream_gen_tick.sv | 30 +++
 rtl/w_stream_gen.sv | 126 ++++++++++++
 tb/tb_w_stream_gen.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/w_stream_gen_pkg.sv
// -----------------------------------------------------------------------------
// w_stream_gen_pkg
// Shared definitions for the serial stimulus source: controller state
// encodings (also used by the downstream FSM block and its bench), default
// geometry constants and a counter-width helper.
// No ports (package).
// -----------------------------------------------------------------------------
package w_stream_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DIV   = 1;

  // Width of a counter that must hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/w_stream_gen_if.sv
// -----------------------------------------------------------------------------
// w_stream_gen_if
// Request/stream bundle between a pattern controller and w_stream_gen.
//   start    : request, honoured only when the generator is idle/done
//   pattern  : WIDTH bits, bit 0 sent first
//   len      : bit count, 0 or >WIDTH means WIDTH
//   w        : serial bit toward the FSM
//   w_valid  : w carries a pattern bit
//   busy     : transfer in progress
//   done     : one-cycle completion pulse
// modport master : generator side (drives the stream)
// modport slave  : controller side (drives the request)
// -----------------------------------------------------------------------------
interface w_stream_gen_if #(
  parameter int WIDTH = 16
);
  localparam int LW = $clog2(WIDTH + 1);

  logic             start;
  logic [WIDTH-1:0] pattern;
  logic [LW-1:0]    len;
  logic             w;
  logic             w_valid;
  logic             busy;
  logic             done;

  modport master (
    input  start, pattern, len,
    output w, w_valid, busy, done
  );

  modport slave (
    output start, pattern, len,
    input  w, w_valid, busy, done
  );
endinterface

// File: rtl/w_stream_gen_tick.sv
// -----------------------------------------------------------------------------
// wstream_tick
// Bit-period prescaler for w_stream_gen. Counts 0..DIV-1 and flags the
// terminal count combinationally so the owner can act on the same edge.
//   clk   : clock
//   reset : synchronous active-high reset
//   clr   : synchronous clear, holds the count at 0
//   tc    : high while the count equals DIV-1 (always high when DIV=1)
// -----------------------------------------------------------------------------
module wstream_tick
  import w_stream_gen_pkg::*;
#(
  parameter int DIV = DEF_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tc
);
  localparam int CW = cnt_width(DIV);

  logic [CW-1:0] cnt_reg;

  assign tc = (cnt_reg == CW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (reset || clr || tc) cnt_reg <= '0;
    else                    cnt_reg <= cnt_reg + 1'b1;
  end
endmodule

// File: rtl/w_stream_gen.sv
// -----------------------------------------------------------------------------
// w_stream_gen
// Serial stimulus source for the FSM block's w input. On an accepted start
// it captures pattern/len and shifts the pattern out LSB-first, each bit held
// for DIV clocks, then pulses done for one cycle. All outputs are registered.
//   clk         : clock, rising edge
//   reset       : synchronous active-high reset (wins over start)
//   repeat_mode : (WSTREAM_REPEAT_EN only) at the end of a word, restart
//                 the captured pattern instead of finishing
//   bus         : w_stream_gen_if.master (start/pattern/len in,
//                 w/w_valid/busy/done out)
// Optional feature macro: WSTREAM_REPEAT_EN
// -----------------------------------------------------------------------------
module w_stream_gen
  import w_stream_gen_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIV   = DEF_DIV
) (
  input  logic clk,
  input  logic reset,
`ifdef WSTREAM_REPEAT_EN
  input  logic repeat_mode,
`endif
  w_stream_gen_if.master bus
);
  localparam int IW = $clog2(WIDTH);
  localparam int LW = $clog2(WIDTH + 1);

  state_t           state_reg;
  logic [WIDTH-1:0] shreg_reg;
  logic [WIDTH-1:0] cap_reg;
  logic [IW-1:0]    bit_idx_reg;
  logic [IW-1:0]    last_idx_reg;
  logic             w_reg, w_valid_reg, busy_reg, done_reg;

  logic             tick_tc;
  logic [IW-1:0]    last_next;
  logic             wrap;

`ifdef WSTREAM_REPEAT_EN
  assign wrap = repeat_mode;
`else
  assign wrap = 1'b0;
`endif

  // Out-of-range lengths collapse to a full-width word; store the index of
  // the final bit so the end test is a plain equality.
  always_comb begin
    last_next = IW'(WIDTH - 1);
    if (bus.len != '0 && bus.len <= LW'(WIDTH))
      last_next = IW'(bus.len - LW'(1));
  end

  // Prescaler runs only while shifting, so every word starts on a fresh period.
  wstream_tick #(.DIV(DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .clr   (state_reg != ST_SHIFT),
    .tc    (tick_tc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      shreg_reg    <= '0;
      cap_reg      <= '0;
      bit_idx_reg  <= '0;
      last_idx_reg <= '0;
      w_reg        <= 1'b0;
      w_valid_reg  <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          done_reg <= 1'b0;
          if (bus.start) begin
            state_reg    <= ST_SHIFT;
            shreg_reg    <= bus.pattern;
            cap_reg      <= bus.pattern;
            last_idx_reg <= last_next;
            bit_idx_reg  <= '0;
            w_reg        <= bus.pattern[0];
            w_valid_reg  <= 1'b1;
            busy_reg     <= 1'b1;
          end else begin
            state_reg    <= ST_IDLE;
            w_reg        <= 1'b0;
            w_valid_reg  <= 1'b0;
            busy_reg     <= 1'b0;
          end
        end
        ST_SHIFT: begin
          if (tick_tc) begin
            if (bit_idx_reg == last_idx_reg) begin
              if (wrap) begin
                // Seamless restart: no gap, no done pulse.
                shreg_reg   <= cap_reg;
                bit_idx_reg <= '0;
                w_reg       <= cap_reg[0];
              end else begin
                state_reg   <= ST_DONE;
                w_reg       <= 1'b0;
                w_valid_reg <= 1'b0;
                busy_reg    <= 1'b0;
                done_reg    <= 1'b1;
              end
            end else begin
              // w is registered, so present the bit that becomes shreg[0].
              shreg_reg   <= {1'b0, shreg_reg[WIDTH-1:1]};
              bit_idx_reg <= bit_idx_reg + 1'b1;
              w_reg       <= shreg_reg[1];
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign bus.w       = w_reg;
  assign bus.w_valid = w_valid_reg;
  assign bus.busy    = busy_reg;
  assign bus.done    = done_reg;
endmodule

// File: tb/tb_w_stream_gen.sv
// -----------------------------------------------------------------------------
// tb_w_stream_gen
// Drives one stimulus stream into two generators (DIV=1 and DIV=3) and checks
// every cycle against a timeline model: a word accepted at edge k shows bit
// (t-1)/DIV in cycle k+t for t=1..L*DIV and done in cycle k+L*DIV+1.
// Also applies a table of explicit vectors and a few directed sequences.
// -----------------------------------------------------------------------------
module tb_w_stream_gen;
  localparam int W  = 16;
  localparam int LW = $clog2(W + 1);

  typedef struct {
    logic          rst;
    logic          start;
    logic [W-1:0]  pat;
    logic [LW-1:0] len;
    logic          w, v, b, d;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          start_s;
  logic [W-1:0]  pat_s;
  logic [LW-1:0] len_s;
  logic          rpt_s;

  w_stream_gen_if #(.WIDTH(W)) bus1 ();
  w_stream_gen_if #(.WIDTH(W)) bus3 ();

  assign bus1.start   = start_s;
  assign bus1.pattern = pat_s;
  assign bus1.len     = len_s;
  assign bus3.start   = start_s;
  assign bus3.pattern = pat_s;
  assign bus3.len     = len_s;

  w_stream_gen #(.WIDTH(W), .DIV(1)) dut1 (
    .clk         (clk),
    .reset       (reset),
`ifdef WSTREAM_REPEAT_EN
    .repeat_mode (rpt_s),
`endif
    .bus         (bus1)
  );

  w_stream_gen #(.WIDTH(W), .DIV(3)) dut3 (
    .clk         (clk),
    .reset       (reset),
`ifdef WSTREAM_REPEAT_EN
    .repeat_mode (rpt_s),
`endif
    .bus         (bus3)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Timeline model state, index 0 = DIV 1, index 1 = DIV 3.
  int           m_div [2] = '{1, 3};
  bit           m_act [2];
  int           m_t   [2];
  int           m_len [2];
  logic [W-1:0] m_cap [2];

  function automatic logic [3:0] model_out(input int m);
    int span;
    span = m_len[m] * m_div[m];
    if (m_act[m] && m_t[m] <= span)
      return {m_cap[m][(m_t[m] - 1) / m_div[m]], 3'b110};
    if (m_act[m] && m_t[m] == span + 1)
      return 4'b0001;
    return 4'b0000;
  endfunction

  task automatic model_edge(input int m);
    int span;
    span = m_len[m] * m_div[m];
    if (reset) begin
      m_act[m] = 1'b0;
    end else if (m_act[m] && m_t[m] == span && rpt_s) begin
      m_t[m] = 1;
    end else if ((!m_act[m] || m_t[m] == span + 1) && start_s) begin
      m_act[m] = 1'b1;
      m_t[m]   = 1;
      m_cap[m] = pat_s;
      m_len[m] = (len_s == 0 || len_s > W) ? W : int'(len_s);
    end else if (m_act[m]) begin
      m_t[m]++;
      if (m_t[m] > span + 1) m_act[m] = 1'b0;
    end
  endtask

  task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s cyc %0d got {w,v,b,d}=%b want %b", name, cyc, got, exp);
    end
  endtask

  // One clock: model advances on the same edge the DUTs sample, outputs
  // compared 1 ns later.
  task automatic step();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    cyc++;
    chk("model_div1", {bus1.w, bus1.w_valid, bus1.busy, bus1.done}, model_out(0));
    chk("model_div3", {bus3.w, bus3.w_valid, bus3.busy, bus3.done}, model_out(1));
  endtask

  task automatic idle(input int n);
    start_s = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  function automatic vec_t mk(input logic rst, input logic st, input logic [W-1:0] p,
                              input logic [LW-1:0] l, input logic [3:0] e);
    vec_t v;
    v.rst = rst; v.start = st; v.pat = p; v.len = l;
    {v.w, v.v, v.b, v.d} = e;
    return v;
  endfunction

  vec_t tbl [18];
  logic ew [8]   = '{0, 0, 0, 0, 1, 1, 1, 1};
  logic exp3 [9] = '{1, 1, 1, 0, 0, 0, 1, 1, 1};

  initial begin
    reset = 1'b1; start_s = 1'b0; pat_s = '0; len_s = '0; rpt_s = 1'b0;
    for (int m = 0; m < 2; m++) begin
      m_act[m] = 1'b0; m_t[m] = 0; m_len[m] = W; m_cap[m] = '0;
    end

    // Reset 3 cycles, idle 5, then 0x00F0/len 8 on the DIV=1 unit. The
    // pattern input changes to all-ones after capture and must not matter.
    for (int i = 0; i < 3; i++) tbl[i] = mk(1'b1, 1'b0, 16'h0000, 5'd0, 4'b0000);
    for (int i = 3; i < 8; i++) tbl[i] = mk(1'b0, 1'b0, 16'h0000, 5'd0, 4'b0000);
    tbl[8] = mk(1'b0, 1'b1, 16'h00F0, 5'd8, {ew[0], 3'b110});
    for (int i = 9; i < 16; i++) tbl[i] = mk(1'b0, 1'b0, 16'hFFFF, 5'd8, {ew[i-8], 3'b110});
    tbl[16] = mk(1'b0, 1'b0, 16'hFFFF, 5'd8, 4'b0001);
    tbl[17] = mk(1'b0, 1'b0, 16'hFFFF, 5'd8, 4'b0000);

    for (int i = 0; i < 18; i++) begin
      reset = tbl[i].rst; start_s = tbl[i].start; pat_s = tbl[i].pat; len_s = tbl[i].len;
      step();
      chk("table", {bus1.w, bus1.w_valid, bus1.busy, bus1.done},
          {tbl[i].w, tbl[i].v, tbl[i].b, tbl[i].d});
    end
    idle(30);

    // DIV=3, 0b101 len 3, stray start at edge k+4 ignored, done at k+10.
    pat_s = 16'h0005; len_s = 5'd3; start_s = 1'b1;
    step();
    chk("div3_bit", {bus3.w, bus3.w_valid, bus3.busy, bus3.done}, {exp3[0], 3'b110});
    for (int i = 2; i <= 10; i++) begin
      start_s = (i == 5);
      if (i == 5) pat_s = 16'h0000;
      step();
      if (i <= 9)
        chk("div3_bit", {bus3.w, bus3.w_valid, bus3.busy, bus3.done}, {exp3[i-1], 3'b110});
      else
        chk("div3_done", {bus3.w, bus3.w_valid, bus3.busy, bus3.done}, 4'b0001);
    end
    idle(30);

    // Continuous start, len 2, pattern 2'b10; pattern flips mid-word.
    pat_s = 16'h0002; len_s = 5'd2; start_s = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (i == 4) pat_s = 16'h0001;
      step();
    end
    idle(30);

    // len 0 runs a full 16-bit word.
    pat_s = 16'hA5C3; len_s = 5'd0; start_s = 1'b1;
    step();
    idle(60);

    // len 0 with reset at edge k+5: outputs clear at k+6, no done.
    pat_s = 16'hFFFF; len_s = 5'd0; start_s = 1'b1;
    step();
    idle(4);
    reset = 1'b1;
    step();
    chk("reset_mid_div1", {bus1.w, bus1.w_valid, bus1.busy, bus1.done}, 4'b0000);
    chk("reset_mid_div3", {bus3.w, bus3.w_valid, bus3.busy, bus3.done}, 4'b0000);
    reset = 1'b0;
    idle(20);

    // Reset and start on the same edge: reset wins.
    reset = 1'b1; start_s = 1'b1; pat_s = 16'h0001; len_s = 5'd1;
    step();
    chk("reset_vs_start", {bus1.w, bus1.w_valid, bus1.busy, bus1.done}, 4'b0000);
    reset = 1'b0;
    idle(10);

`ifdef WSTREAM_REPEAT_EN
    // Repeat: 4'b1011 len 4 loops without a gap, then finishes normally.
    rpt_s = 1'b1; pat_s = 16'h000B; len_s = 5'd4; start_s = 1'b1;
    step();
    start_s = 1'b0;
    for (int i = 0; i < 30; i++) step();
    rpt_s = 1'b0;
    idle(40);
`endif

    // Randomised traffic.
    for (int i = 0; i < 4000; i++) begin
      reset   = ($urandom_range(0, 149) == 0);
      start_s = ($urandom_range(0, 2) == 0);
      pat_s   = W'($urandom);
      len_s   = LW'($urandom_range(0, 31));
`ifdef WSTREAM_REPEAT_EN
      rpt_s   = ($urandom_range(0, 3) == 0);
`endif
      step();
    end
    reset = 1'b0; rpt_s = 1'b0;
    idle(60);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
